// File: rtl/digit_argmax.sv
// digit_argmax: captures softmax scores, scans one class per cycle for the max.
// Optional runner-up/margin outputs when DIGIT_ARGMAX_TOP2_EN is defined.
module digit_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W = 16,
  parameter int IDX_W = 4,
  parameter logic [SCORE_W-1:0] CONF_THRESH = 16'h4000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
  input  logic                           scores_valid,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [IDX_W-1:0]               class_idx,
  output logic [SCORE_W-1:0]             class_score,
  output logic                           confident,
`ifdef DIGIT_ARGMAX_TOP2_EN
  output logic [IDX_W-1:0]               second_idx,
  output logic [SCORE_W-1:0]             margin,
`endif
  output logic                           busy,
  output logic                           overrun
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [SCORE_W-1:0] score_buf [NUM_CLASSES];
  logic [IDX_W-1:0]   scan_i;
  logic [IDX_W-1:0]   best_idx, best_idx_nx;
  logic [SCORE_W-1:0] best_score, best_score_nx;
  logic [SCORE_W-1:0] cand;
  logic               take_best;
  logic               last;
  logic               capture;
  logic               conf_nx;

`ifdef DIGIT_ARGMAX_TOP2_EN
  localparam logic [SCORE_W-1:0] MARGIN_MIN = CONF_THRESH >> 2;

  logic [IDX_W-1:0]   sec_idx, sec_idx_nx;
  logic [SCORE_W-1:0] sec_score, sec_score_nx;
  logic               sec_vld, sec_vld_nx;
  logic [SCORE_W-1:0] margin_nx;
`endif

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign capture   = (state == IDLE) && scores_valid;
  assign last      = (scan_i == LAST);

  // Scan step: index 0 is re-compared against itself, giving N scan edges.
  always_comb begin
    cand          = score_buf[scan_i];
    take_best     = cand > best_score;
    best_idx_nx   = take_best ? scan_i : best_idx;
    best_score_nx = take_best ? cand : best_score;
  end

`ifdef DIGIT_ARGMAX_TOP2_EN
  // Runner-up: old best drops to second, else strictly greater candidate wins.
  always_comb begin
    sec_idx_nx   = sec_idx;
    sec_score_nx = sec_score;
    sec_vld_nx   = sec_vld;
    if (take_best) begin
      sec_idx_nx   = best_idx;
      sec_score_nx = best_score;
      sec_vld_nx   = 1'b1;
    end else if (scan_i != '0 &&
                 (!sec_vld || cand > sec_score)) begin
      sec_idx_nx   = scan_i;
      sec_score_nx = cand;
      sec_vld_nx   = 1'b1;
    end
  end

  assign margin_nx = best_score_nx - sec_score_nx;
  assign conf_nx   = (best_score_nx >= CONF_THRESH) &&
                     (margin_nx >= MARGIN_MIN);
`else
  assign conf_nx = (best_score_nx >= CONF_THRESH);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (scores_valid) state_nx = SCAN;
      SCAN: if (last) state_nx = HOLD;
      HOLD: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture, scan datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLASSES; k++)
        score_buf[k] <= '0;
      scan_i      <= '0;
      best_idx    <= '0;
      best_score  <= '0;
      class_idx   <= '0;
      class_score <= '0;
      confident   <= 1'b0;
`ifdef DIGIT_ARGMAX_TOP2_EN
      sec_idx     <= '0;
      sec_score   <= '0;
      sec_vld     <= 1'b0;
      second_idx  <= '0;
      margin      <= '0;
`endif
    end else if (capture) begin
      for (int k = 0; k < NUM_CLASSES; k++)
        score_buf[k] <= scores_in[k*SCORE_W +: SCORE_W];
      scan_i     <= '0;
      best_idx   <= '0;
      best_score <= scores_in[SCORE_W-1:0];
`ifdef DIGIT_ARGMAX_TOP2_EN
      sec_idx    <= '0;
      sec_score  <= '0;
      sec_vld    <= 1'b0;
`endif
    end else if (state == SCAN) begin
      scan_i     <= scan_i + IDX_W'(1);
      best_idx   <= best_idx_nx;
      best_score <= best_score_nx;
`ifdef DIGIT_ARGMAX_TOP2_EN
      sec_idx    <= sec_idx_nx;
      sec_score  <= sec_score_nx;
      sec_vld    <= sec_vld_nx;
`endif
      if (last) begin
        class_idx   <= best_idx_nx;
        class_score <= best_score_nx;
        confident   <= conf_nx;
`ifdef DIGIT_ARGMAX_TOP2_EN
        second_idx  <= sec_idx_nx;
        margin      <= margin_nx;
`endif
      end
    end
  end

  // Sticky flag for score pulses arriving while not idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overrun <= 1'b0;
    else if (scores_valid && state != IDLE)
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_digit_argmax.sv
// tb_digit_argmax: directed vectors, reference argmax model, per-cycle compare.
// Build with DIGIT_ARGMAX_TOP2_EN to cover the runner-up outputs.
module tb_digit_argmax;

  localparam int NC = 10;
  localparam int SW = 16;
  localparam int IW = 4;

  typedef logic [SW-1:0] vec_t [NC];

  logic            clk = 1'b0;
  logic            rst;
  logic [NC*SW-1:0] sin;
  logic            sv;
  logic            ordy;
  logic            out_valid;
  logic [IW-1:0]   class_idx;
  logic [SW-1:0]   class_score;
  logic            confident;
  logic            busy;
  logic            overrun;
`ifdef DIGIT_ARGMAX_TOP2_EN
  logic [IW-1:0]   second_idx;
  logic [SW-1:0]   margin;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int          exp_idx;
  logic [SW-1:0] exp_score;
  logic        exp_conf;
  int          exp_sec;
  logic [SW-1:0] exp_margin;
  logic        exp_ovr;

  digit_argmax dut (
    .clk          (clk),
    .rst          (rst),
    .scores_in    (sin),
    .scores_valid (sv),
    .out_ready    (ordy),
    .out_valid    (out_valid),
    .class_idx    (class_idx),
    .class_score  (class_score),
    .confident    (confident),
`ifdef DIGIT_ARGMAX_TOP2_EN
    .second_idx   (second_idx),
    .margin       (margin),
`endif
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [NC*SW-1:0] pack(input vec_t v);
    logic [NC*SW-1:0] p;
    p = '0;
    for (int k = 0; k < NC; k++) p[k*SW +: SW] = v[k];
    return p;
  endfunction

  // Reference: first maximum wins; runner-up is first maximum of the rest.
  task automatic model(input vec_t v);
    int bi;
    int si;
    bi = 0;
    for (int k = 1; k < NC; k++) if (v[k] > v[bi]) bi = k;
    si = (bi == 0) ? 1 : 0;
    for (int k = 0; k < NC; k++)
      if (k != bi && v[k] > v[si]) si = k;
    exp_idx    = bi;
    exp_score  = v[bi];
    exp_sec    = si;
    exp_margin = v[bi] - v[si];
`ifdef DIGIT_ARGMAX_TOP2_EN
    exp_conf = (v[bi] >= 16'h4000) && (exp_margin >= 16'h1000);
`else
    exp_conf = (v[bi] >= 16'h4000);
`endif
  endtask

  // Per-cycle compare against the model and reset values.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_idx", class_idx, 0);
      chk("rst_score", class_score, 0);
      chk("rst_conf", confident, 0);
`ifdef DIGIT_ARGMAX_TOP2_EN
      chk("rst_second", second_idx, 0);
      chk("rst_margin", margin, 0);
`endif
    end else begin
      chk("overrun", overrun, exp_ovr);
      if (out_valid) begin
        chk("idx", class_idx, exp_idx);
        chk("score", class_score, exp_score);
        chk("conf", confident, exp_conf);
        chk("busy_hold", busy, 1);
`ifdef DIGIT_ARGMAX_TOP2_EN
        chk("second", second_idx, exp_sec);
        chk("margin", margin, exp_margin);
`endif
      end
    end
  end

  task automatic send(input vec_t v);
    int lat;
    sin = pack(v);
    sv  = 1'b1;
    model(v);
    @(posedge clk);
    #1;
    sv  = 1'b0;
    sin = ~sin;
    chk("busy_after_capture", busy, 1);
    chk("valid_after_capture", out_valid, 0);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk("latency", lat, NC);
  endtask

  task automatic accept();
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_valid", out_valid, 0);
    chk("accept_busy", busy, 0);
    ordy = 1'b0;
  endtask

  vec_t v;

  initial begin
    rst = 1'b1; sv = 1'b0; ordy = 1'b0; sin = '0; exp_ovr = 1'b0;
    exp_idx = 0; exp_score = '0; exp_conf = 1'b0;
    exp_sec = 0; exp_margin = '0;
    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic ordering, out_ready already high.
    ordy = 1'b1;
    v = '{16'd100, 16'd200, 16'd300, 16'd50, 16'd900,
          16'd10, 16'd0, 16'd0, 16'd0, 16'd0};
    send(v);
    chk("t1_idx", class_idx, 4);
    chk("t1_score", class_score, 900);
    chk("t1_conf", confident, 0);
    accept();

    // Dominant class 7.
    v = '{default: 16'h0100};
    v[7] = 16'h8000;
    send(v);
    chk("t2_idx", class_idx, 7);
    chk("t2_conf", confident, 1);
`ifdef DIGIT_ARGMAX_TOP2_EN
    chk("t2_second", second_idx, 0);
    chk("t2_margin", margin, 16'h7F00);
`endif
    accept();

    // Tie at exactly the threshold.
    v = '{default: 16'h0000};
    v[2] = 16'h4000;
    v[5] = 16'h4000;
    send(v);
    chk("t3_idx", class_idx, 2);
    chk("t3_score", class_score, 16'h4000);
`ifdef DIGIT_ARGMAX_TOP2_EN
    chk("t3_conf", confident, 0);
    chk("t3_second", second_idx, 5);
    chk("t3_margin", margin, 0);
`else
    chk("t3_conf", confident, 1);
`endif
    accept();

    // Back-to-back capture on the cycle after acceptance.
    v = '{16'd5, 16'd9, 16'd9, 16'd1, 16'd0,
          16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send(v);
    chk("t4_idx", class_idx, 1);
    chk("t4_score", class_score, 9);
    chk("t4_overrun", overrun, 0);
    accept();

    // All-zero scores.
    v = '{default: 16'h0000};
    send(v);
    chk("t5_idx", class_idx, 0);
    chk("t5_score", class_score, 0);
    chk("t5_conf", confident, 0);
    accept();

    // Long hold with a stray scores_valid pulse.
    v = '{default: 16'h0001};
    v[9] = 16'hFFFF;
    send(v);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        v = '{default: 16'h7777};
        sin = pack(v);
        sv = 1'b1;
      end
      @(posedge clk);
      #1;
      if (c == 5) begin
        sv = 1'b0;
        exp_ovr = 1'b1;
      end
      chk("t6_hold_valid", out_valid, 1);
    end
    chk("t6_idx", class_idx, 9);
    chk("t6_score", class_score, 16'hFFFF);
    chk("t6_overrun", overrun, 1);
    accept();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk("t6_no_second_valid", out_valid, 0);
      chk("t6_no_second_busy", busy, 0);
    end

    // Reset in the middle of a scan.
    v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
          16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    sin = pack(v);
    sv = 1'b1;
    @(posedge clk);
    #1;
    sv = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_ovr = 1'b0;
    #1;
    chk("t7_async_valid", out_valid, 0);
    chk("t7_async_busy", busy, 0);
    chk("t7_async_idx", class_idx, 0);
    chk("t7_async_score", class_score, 0);
    chk("t7_async_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    v = '{16'd3, 16'd0, 16'd0, 16'd0, 16'd0,
          16'd0, 16'd0, 16'd0, 16'h5000, 16'd0};
    send(v);
    chk("t7_idx", class_idx, 8);
    chk("t7_score", class_score, 16'h5000);
    chk("t7_conf", confident, 1);
    accept();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
